// File: rtl/serializador_bits_if.sv
// serializador_bits_if: byte valid/ready handshake between producer and serializer.
interface serializador_bits_if;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic       byte_ready;
  modport master(output byte_valid, byte_in, input byte_ready);
  modport slave(input byte_valid, byte_in, output byte_ready);
endinterface

// File: rtl/serializador_bits.sv
// serializador_bits: byte FIFO feeding a 1-bit/cycle serializer with a stream start pulse.
// Define SERIALIZADOR_LSB_FIRST_EN for LSB-first bit order (default MSB first).
module serializador_bits #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  serializador_bits_if.slave bus,
  input  logic              flush,
  output logic              start,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count, count_n;
  logic [7:0] sr, sr_n, head;
  logic [2:0] cnt, cnt_n;
  logic push, pop, start_n, bit_out_n, bit_valid_n;
`ifdef SERIALIZADOR_LSB_FIRST_EN
  function automatic logic first_bit(input logic [7:0] b);
    return b[0];
  endfunction
  function automatic logic [7:0] advance(input logic [7:0] b);
    return b >> 1;
  endfunction
`else
  function automatic logic first_bit(input logic [7:0] b);
    return b[7];
  endfunction
  function automatic logic [7:0] advance(input logic [7:0] b);
    return b << 1;
  endfunction
`endif
  assign bus.byte_ready = count != (PW+1)'(FIFO_DEPTH);
  assign push = bus.byte_valid && bus.byte_ready && !flush;
  assign head = mem[rd_ptr];
  assign count_n = flush ? '0 : count + (PW+1)'(push) - (PW+1)'(pop);
  // sr holds the not-yet-emitted bits aligned so first_bit() yields the next one
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
    pop = 1'b0;
    start_n = 1'b0;
    bit_valid_n = bit_valid;
    bit_out_n = bit_out;
    if (flush) begin
      state_n = IDLE;
      cnt_n = '0;
      bit_valid_n = 1'b0;
      bit_out_n = 1'b0;
    end else if (state == IDLE || cnt == 3'd7) begin
      pop = count != '0;
      state_n = pop ? SHIFT : IDLE;
      start_n = pop && state == IDLE;
      cnt_n = '0;
      bit_valid_n = pop;
      bit_out_n = pop && first_bit(head);
      sr_n = pop ? advance(head) : sr;
    end else begin
      cnt_n = cnt + 3'd1;
      bit_out_n = first_bit(sr);
      sr_n = advance(sr);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      start <= 1'b0;
      bit_out <= 1'b0;
      bit_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
      wr_ptr <= flush ? '0 : wr_ptr + PW'(push);
      rd_ptr <= flush ? '0 : rd_ptr + PW'(pop);
      count <= count_n;
      start <= start_n;
      bit_out <= bit_out_n;
      bit_valid <= bit_valid_n;
      busy <= state_n == SHIFT || count_n != '0;
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= bus.byte_in;
endmodule

// File: tb/tb_serializador_bits.sv
// tb_serializador_bits: table-driven vectors plus directed multi-cycle sequences.
module tb_serializador_bits;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic start, bit_out, bit_valid, busy;
  int passed = 0, total = 0;
  logic [7:0] q[$];
  logic [7:0] fb[8];
  typedef struct {
    logic r, f, v;
    logic [7:0] d;
    logic s, b, bv, bz, rdy;
  } vec_t;
  vec_t tbl[13];
  serializador_bits_if bus();
  serializador_bits #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
    .start(start), .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic eb(input logic [7:0] b, input int i);
`ifdef SERIALIZADOR_LSB_FIRST_EN
    return b[i];
`else
    return b[7-i];
`endif
  endfunction
  task automatic chk(input string name, input logic a, input logic e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", name, a, e, $time);
  endtask
  task automatic step(input logic r, input logic f, input logic v, input logic [7:0] d);
    rst_n = r;
    flush = f;
    bus.byte_valid = v;
    bus.byte_in = d;
    @(posedge clk);
    #1;
  endtask
  task automatic check_stream(input int skip);
    for (int p = skip; p < 8 * q.size(); p++) begin
      chk("stream_start", start, p == 0);
      chk("stream_valid", bit_valid, 1'b1);
      chk("stream_bit", bit_out, eb(q[p/8], p % 8));
      step(1, 0, 0, 8'h00);
    end
    chk("end_valid", bit_valid, 1'b0);
    chk("end_start", start, 1'b0);
    chk("end_bit", bit_out, 1'b0);
    chk("end_busy", busy, 1'b0);
    chk("end_ready", bus.byte_ready, 1'b1);
  endtask
  initial begin
    bus.byte_valid = 1'b1;
    bus.byte_in = 8'h55;
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    fb = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1};
    // reset with byte_valid held, then a single A5 (palindrome, same in both bit orders)
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_start", i), start, tbl[i].s);
      chk($sformatf("tbl%0d_bit", i), bit_out, tbl[i].b);
      chk($sformatf("tbl%0d_valid", i), bit_valid, tbl[i].bv);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bz);
      chk($sformatf("tbl%0d_ready", i), bus.byte_ready, tbl[i].rdy);
    end
    step(1, 0, 1, 8'h0F);
    step(1, 0, 0, 8'h00);
    q = '{8'h0F};
    check_stream(0);
    step(1, 0, 1, 8'h0F);
    step(1, 0, 1, 8'hF0);
    q = '{8'h0F, 8'hF0};
    check_stream(0);
    // byte_valid held 8 cycles: 5 bytes fit (one popped immediately, four queued)
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1, fb[i]);
      chk($sformatf("full_ready%0d", i), bus.byte_ready, i < 4);
      if (i >= 1) begin
        chk($sformatf("full_bit%0d", i), bit_out, eb(fb[0], i - 1));
        chk($sformatf("full_start%0d", i), start, i == 1);
      end
    end
    q = '{fb[0], fb[1], fb[2], fb[3], fb[4]};
    check_stream(6);
    step(1, 0, 1, 8'hFF);
    step(1, 0, 1, 8'h11);
    step(1, 0, 1, 8'h22);
    step(1, 0, 0, 8'h00);
    chk("pre_flush_valid", bit_valid, 1'b1);
    step(1, 1, 1, 8'h33);
    chk("flush_valid", bit_valid, 1'b0);
    chk("flush_bit", bit_out, 1'b0);
    chk("flush_start", start, 1'b0);
    chk("flush_busy", busy, 1'b0);
    chk("flush_ready", bus.byte_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 8'h00);
      chk($sformatf("post_flush_valid%0d", i), bit_valid, 1'b0);
      chk($sformatf("post_flush_busy%0d", i), busy, 1'b0);
    end
    step(1, 0, 1, 8'hC3);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'h00);
    chk("pre_rst_bit5", bit_out, eb(8'hC3, 4));
    step(0, 0, 0, 8'h00);
    chk("rst_valid", bit_valid, 1'b0);
    chk("rst_bit", bit_out, 1'b0);
    chk("rst_start", start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", bus.byte_ready, 1'b1);
    step(1, 0, 1, 8'h3C);
    step(1, 0, 0, 8'h00);
    q = '{8'h3C};
    check_stream(0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serializador_bits.md
# serializador_bits

Upstream feeder for the bit-sequence detector. It accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and shifts them out one bit per clock. It drives a one-cycle `start` pulse at the beginning of each contiguous bit stream, plus `bit_out` and `bit_valid`. These map directly onto the detector's `start`/`bit_in` inputs.

## Interface
- `FIFO_DEPTH`, default 4: byte FIFO entries; power of two, at least 2.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `byte_valid`  in  1  producer offers `byte_in` this cycle.
- `byte_in`  in  8  data byte.
- `byte_ready`  out  1  FIFO can accept; combinational `!full`.
- `flush`  in  1  synchronous abort: empties FIFO, stops shifting.
- `start`  out  1  one-cycle pulse with the first bit of a stream.
- `bit_out`  out  1  serial data bit.
- `bit_valid`  out  1  `bit_out` is a real data bit this cycle.
- `busy`  out  1  FIFO non-empty or shift in progress.

## Operation
- **Reset** (`rst_n`=0 at an edge):
  - FIFO pointers and count cleared; FSM to IDLE; bit counter 0.
  - Outputs: `start`=0, `bit_out`=0, `bit_valid`=0, `busy`=0. `byte_ready` reads 1 once count is 0.
  - Reset overrides every other input.
- **Push:** occurs when `byte_valid && byte_ready`. Bytes offered while full are ignored; the producer must hold them.
- **FIFO:**
  - Circular buffer; read and write pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally.
  - Count is one bit wider than the pointers.
  - A simultaneous push and pop leaves the count unchanged.
- **FSM states:**
  - IDLE → SHIFT when the FIFO is non-empty: pop one byte into the shift register, bit counter = 0, `start`=1, `bit_valid`=1.
  - SHIFT: emit one bit per cycle; bit counter increments 0..7.
  - SHIFT at counter 7, FIFO non-empty: pop the next byte and continue on the very next cycle. No gap and no new `start`.
  - SHIFT at counter 7, FIFO empty: → IDLE; `bit_valid`=0, `bit_out`=0.
- **Output rules:**
  - `start` is high only on the first bit after IDLE; otherwise 0.
  - In IDLE, `bit_out` is forced to 0.
- **flush** (priority below reset, above everything else):
  - Next edge: FIFO emptied, FSM to IDLE, `start`/`bit_valid`/`bit_out` = 0.
  - A push in the same cycle as `flush` is dropped.
- **`busy`:** registered; high when state is SHIFT or count ≠ 0 after the edge.

## Timing
- Byte pushed at edge k, FIFO previously empty, FSM in IDLE:
  - After edge k+1: first bit on `bit_out` with `start`=1.
  - Bits 2..8 follow after edges k+2..k+8.
- Sustained throughput: 1 bit/cycle, 1 byte per 8 cycles, provided the next byte is in the FIFO before the current byte's counter reaches 7.
- All outputs except `byte_ready` are registered. `byte_ready` reflects the count after the previous edge.
- Reset or `flush` mid-byte: remaining bits of that byte are discarded; `bit_valid` drops after that edge.

## Configuration
- Macro `SERIALIZADOR_LSB_FIRST_EN`.
- Undefined: MSB first (`byte_in[7]` first). This makes the last 8 bits of a stream equal the byte as assembled by a left-shifting detector.
- Defined: LSB first (`byte_in[0]` first). Bit-order selection only; all timing is unchanged.

## Test plan
- **Reset:** assert `rst_n`=0 for 2 cycles with `byte_valid`=1 → `start`=`bit_valid`=`bit_out`=`busy`=0; `byte_ready`=1 after release; no byte stored.
- **Single byte:** push 8'hA5 → `start` high 1 cycle; `bit_out` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with `bit_valid`=1; then `bit_valid`=0 and `busy`=0. With the macro defined: 1,0,1,0,0,1,0,1 reversed, i.e. 1,0,1,0,0,1,0,1 (A5 is a palindrome). Repeat with 8'h0F, expecting 0,0,0,0,1,1,1,1 / 1,1,1,1,0,0,0,0.
- **Back-to-back:** push 8'h0F then 8'hF0 → 16 contiguous valid bits, exactly one `start` pulse.
- **Full boundary:** `byte_valid` held for 8 cycles (FIFO_DEPTH=4) → `byte_ready` drops when count hits 4; exactly the accepted bytes are emitted in order; none are lost or duplicated.
- **Flush:** assert `flush` at bit 3 of 8'hFF with 2 bytes queued → after the edge `bit_valid`=0, `busy`=0, `byte_ready`=1; no further bits emitted.
- **Reset mid-stream:** `rst_n`=0 during bit 5 → outputs 0 on the next edge; a new byte 8'h3C afterwards streams normally with `start`=1.
